// File: rtl/trng_key_fetch.sv
// TRNG key fetcher: reads key words from a TRNG data register over OBI whenever the
// TRNG signals availability, and buffers them in a small FIFO for a key consumer.
// Optional build macro TRNG_FETCH_HEALTH_EN enables a repetition health check that
// drops a returned word equal to the previous one and pulses repeat_err_o.
module trng_key_fetch #(
  parameter logic [31:0] DATA_ADDR     = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH    = 4,
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          enable_i,
  input  logic                          trng_intr_i,
  output logic                          req_o,
  output logic [31:0]                   addr_o,
  output logic                          we_o,
  output logic [3:0]                    be_o,
  output logic [31:0]                   wdata_o,
  input  logic                          gnt_i,
  input  logic                          rvalid_i,
  input  logic [31:0]                   rdata_i,
  output logic [31:0]                   key_o,
  output logic                          key_valid_o,
  input  logic                          key_ready_i,
  output logic [$clog2(FIFO_DEPTH):0]   level_o,
  output logic                          repeat_err_o
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = AW + 1;

  typedef enum logic [1:0] {StIdle, StReq, StWaitRsp, StSettle} state_e;

  state_e          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [LW-1:0]   level_q, level_d;
  logic [AW-1:0]   wptr_q, rptr_q;
  logic [31:0]     mem_q [FIFO_DEPTH];
  logic            rsp_fire, repeat_hit, push, pop;

  // Read-only bus: the request attributes never change.
  assign addr_o  = DATA_ADDR;
  assign we_o    = 1'b0;
  assign be_o    = 4'hF;
  assign wdata_o = 32'h0;

  assign rsp_fire    = (state_q == StWaitRsp) && rvalid_i;
  assign push        = rsp_fire && !repeat_hit;
  assign key_valid_o = (level_q != '0);
  assign pop         = key_valid_o && key_ready_i;
  assign level_o     = level_q;
  // Gate the head word so key_o reads zero whenever the buffer is empty.
  assign key_o       = key_valid_o ? mem_q[rptr_q] : 32'h0;

`ifdef TRNG_FETCH_HEALTH_EN
  logic [31:0] last_q;
  logic        last_valid_q;
  logic        repeat_err_q;

  assign repeat_hit   = rsp_fire && last_valid_q && (rdata_i == last_q);
  assign repeat_err_o = repeat_err_q;

  // Remember the last returned word and register the repeat pulse.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      last_q       <= 32'h0;
      last_valid_q <= 1'b0;
      repeat_err_q <= 1'b0;
    end else begin
      repeat_err_q <= repeat_hit;
      if (rsp_fire) begin
        last_q       <= rdata_i;
        last_valid_q <= 1'b1;
      end
    end
  end
`else
  assign repeat_hit   = 1'b0;
  assign repeat_err_o = 1'b0;
`endif

  // FSM state and settle counter registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic; a slot is reserved on leaving IDLE, so a push never overflows.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_o   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (enable_i && trng_intr_i && (level_q < LW'(FIFO_DEPTH))) state_d = StReq;
      end
      StReq: begin
        req_o = 1'b1;
        // A grant in the same cycle as enable dropping still commits the transfer.
        if (gnt_i) state_d = StWaitRsp;
        else if (!enable_i) state_d = StIdle;
      end
      StWaitRsp: begin
        if (rvalid_i) begin
          state_d = StSettle;
          cnt_d   = 4'd0;
        end
      end
      StSettle: begin
        if (cnt_q == 4'(SETTLE_CYCLES - 1)) state_d = StIdle;
        else cnt_d = 4'(cnt_q + 4'd1);
      end
      default: state_d = StIdle;
    endcase
  end

  // Occupancy update from push/pop.
  always_comb begin
    level_d = level_q;
    unique case ({push, pop})
      2'b10:   level_d = LW'(level_q + 1'b1);
      2'b01:   level_d = LW'(level_q - 1'b1);
      default: level_d = level_q;
    endcase
  end

  // FIFO pointers and occupancy; pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      level_q <= level_d;
      if (push) wptr_q <= AW'(wptr_q + 1'b1);
      if (pop)  rptr_q <= AW'(rptr_q + 1'b1);
    end
  end

  // FIFO storage; contents need no reset since key_o is gated by occupancy.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wptr_q] <= rdata_i;
  end

endmodule

// File: tb/tb_trng_key_fetch.sv
// Self-checking bench for trng_key_fetch: directed scenarios plus a randomized phase,
// all checked against a transaction-level model (key queue, outstanding flag and a
// post-response quiet window). Honours TRNG_FETCH_HEALTH_EN like the design.
module tb_trng_key_fetch;

  localparam int unsigned DEPTH  = 4;
  localparam int unsigned SETTLE = 2;
  localparam int unsigned LW     = $clog2(DEPTH) + 1;
  localparam logic [31:0] ADDR   = 32'h4000_1000;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          enable = 1'b0, intr = 1'b0, gnt = 1'b0, rvalid = 1'b0, ready = 1'b0;
  logic [31:0]   rdata = 32'h0;
  logic          req_o, we_o, key_valid_o, repeat_err_o;
  logic [31:0]   addr_o, wdata_o, key_o;
  logic [3:0]    be_o;
  logic [LW-1:0] level_o;

  always #5 clk = ~clk;

  trng_key_fetch #(
    .DATA_ADDR    (ADDR),
    .FIFO_DEPTH   (DEPTH),
    .SETTLE_CYCLES(SETTLE)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .enable_i    (enable),
    .trng_intr_i (intr),
    .req_o       (req_o),
    .addr_o      (addr_o),
    .we_o        (we_o),
    .be_o        (be_o),
    .wdata_o     (wdata_o),
    .gnt_i       (gnt),
    .rvalid_i    (rvalid),
    .rdata_i     (rdata),
    .key_o       (key_o),
    .key_valid_o (key_valid_o),
    .key_ready_i (ready),
    .level_o     (level_o),
    .repeat_err_o(repeat_err_o)
  );

  // Reference model state.
  logic [31:0] q[$];
  logic        outstanding;
  int          guard;
  logic [31:0] last_word;
  logic        last_valid;
  logic        rep_exp;
  int          reads, rep_seen;
  logic [31:0] gen_last = 32'h0;

  int n_vec = 0;
  int n_err = 0;

`ifdef TRNG_FETCH_HEALTH_EN
  localparam bit HEALTH = 1'b1;
`else
  localparam bit HEALTH = 1'b0;
`endif

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    q.delete();
    outstanding = 1'b0;
    guard       = 0;
    last_valid  = 1'b0;
    last_word   = 32'h0;
    rep_exp     = 1'b0;
  endtask

  task automatic next_word(output logic [31:0] w);
    do w = $urandom; while (w == gen_last);
    gen_last = w;
  endtask

  // Compare outputs with the model, advance the model with this cycle's inputs, step a clock.
  task automatic tick();
    check_eq("level", 32'(level_o), 32'(q.size()));
    check_eq("key_valid", 32'(key_valid_o), 32'(q.size() != 0));
    if (q.size() != 0) check_eq("key", key_o, q[0]);
    check_eq("repeat_err", 32'(repeat_err_o), 32'(rep_exp));
    if (guard != 0 || outstanding) check_eq("req_quiet", 32'(req_o), 32'h0);
    if (q.size() == DEPTH) check_eq("req_full", 32'(req_o), 32'h0);
    if (req_o) begin
      check_eq("addr", addr_o, ADDR);
      check_eq("we", 32'(we_o), 32'h0);
      check_eq("be", 32'(be_o), 32'hF);
      check_eq("wdata", wdata_o, 32'h0);
    end
    if (repeat_err_o) rep_seen++;
    rep_exp = 1'b0;
    if (q.size() != 0 && ready) void'(q.pop_front());
    if (rvalid && outstanding) begin
      if (HEALTH && last_valid && rdata == last_word) rep_exp = 1'b1;
      else q.push_back(rdata);
      last_word   = rdata;
      last_valid  = 1'b1;
      outstanding = 1'b0;
      guard       = SETTLE + 1;
    end else if (guard != 0) begin
      guard--;
    end
    if (req_o && gnt) begin
      outstanding = 1'b1;
      reads++;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    {enable, intr, gnt, rvalid, ready} = '0;
    model_clear();
    reads    = 0;
    rep_seen = 0;
    @(negedge clk);
    check_eq("rst_req", 32'(req_o), 32'h0);
    check_eq("rst_kvalid", 32'(key_valid_o), 32'h0);
    check_eq("rst_level", 32'(level_o), 32'h0);
    check_eq("rst_rep", 32'(repeat_err_o), 32'h0);
    check_eq("rst_key", key_o, 32'h0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One complete read returning word w; waits a bounded time for the request.
  task automatic do_read(input logic [31:0] w);
    for (int i = 0; i < 20 && !req_o; i++) tick();
    check_eq("read_req_seen", 32'(req_o), 32'h1);
    if (!req_o) return;
    gnt = 1'b1;
    tick();
    gnt    = 1'b0;
    rvalid = 1'b1;
    rdata  = w;
    tick();
    rvalid = 1'b0;
  endtask

  // Always-granting, always-responding slave for n cycles.
  task automatic run_auto(input int n);
    logic [31:0] w;
    for (int i = 0; i < n; i++) begin
      gnt    = req_o;
      rvalid = outstanding;
      if (rvalid) begin
        next_word(w);
        rdata = w;
      end
      tick();
    end
    gnt    = 1'b0;
    rvalid = 1'b0;
  endtask

  initial begin
    logic [31:0] w;
    int          r0;

    // Single read with same-cycle grant and next-cycle response.
    do_reset();
    enable = 1'b1;
    intr   = 1'b1;
    do_read(32'hA5A5_0001);
    check_eq("t038_key", key_o, 32'hA5A5_0001);
    check_eq("t038_level", 32'(level_o), 32'h1);
    check_eq("t038_quiet0", 32'(req_o), 32'h0);
    tick();
    check_eq("t038_quiet1", 32'(req_o), 32'h0);
    intr = 1'b0;
    tick();
    tick();
    check_eq("t038_reads", 32'(reads), 32'h1);

    // Fill with no consumer: exactly DEPTH reads, then one pop allows one more.
    do_reset();
    enable = 1'b1;
    intr   = 1'b1;
    run_auto(60);
    check_eq("t039_reads", 32'(reads), 32'(DEPTH));
    check_eq("t039_level", 32'(level_o), 32'(DEPTH));
    ready = 1'b1;
    tick();
    ready = 1'b0;
    run_auto(20);
    check_eq("t039_reads_after_pop", 32'(reads), 32'(DEPTH + 1));

    // Grant held off for 5 cycles: request and address stay stable.
    do_reset();
    enable = 1'b1;
    intr   = 1'b1;
    tick();
    for (int i = 0; i < 6; i++) begin
      check_eq("t040_req", 32'(req_o), 32'h1);
      check_eq("t040_addr", addr_o, ADDR);
      gnt = (i == 5);
      tick();
    end
    gnt    = 1'b0;
    rvalid = 1'b1;
    next_word(w);
    rdata = w;
    tick();
    rvalid = 1'b0;
    check_eq("t040_reads", 32'(reads), 32'h1);

    // Push and pop together at level 2, then churn to wrap the pointers.
    do_reset();
    enable = 1'b1;
    intr   = 1'b1;
    next_word(w);
    do_read(w);
    next_word(w);
    do_read(w);
    for (int i = 0; i < 20 && !req_o; i++) tick();
    check_eq("t041_req_seen", 32'(req_o), 32'h1);
    gnt = 1'b1;
    tick();
    gnt    = 1'b0;
    rvalid = 1'b1;
    ready  = 1'b1;
    next_word(w);
    rdata = w;
    tick();
    rvalid = 1'b0;
    ready  = 1'b0;
    check_eq("t041_level", 32'(level_o), 32'h2);
    for (int i = 0; i < 60; i++) begin
      ready = ($urandom_range(0, 2) == 0);
      run_auto(1);
    end
    ready = 1'b0;

    // Two identical words back to back.
    do_reset();
    enable = 1'b1;
    intr   = 1'b1;
    do_read(32'h1234_5678);
    do_read(32'h1234_5678);
    intr = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check_eq("t042_level", 32'(level_o), HEALTH ? 32'h1 : 32'h2);
    check_eq("t042_pulses", 32'(rep_seen), HEALTH ? 32'h1 : 32'h0);

    // Reset while waiting for a response; late response must be dropped.
    do_reset();
    enable = 1'b1;
    intr   = 1'b1;
    next_word(w);
    do_read(w);
    for (int i = 0; i < 20 && !req_o; i++) tick();
    gnt = 1'b1;
    tick();
    gnt = 1'b0;
    #2 rst = 1'b1;
    #1;
    check_eq("t043_req", 32'(req_o), 32'h0);
    check_eq("t043_level", 32'(level_o), 32'h0);
    check_eq("t043_kvalid", 32'(key_valid_o), 32'h0);
    model_clear();
    enable = 1'b0;
    intr   = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    tick();
    rvalid = 1'b1;
    next_word(w);
    rdata = w;
    tick();
    rvalid = 1'b0;
    tick();
    check_eq("t043_late_rsp", 32'(level_o), 32'h0);

    // Randomized traffic with occasional repeated words.
    do_reset();
    r0 = 0;
    for (int i = 0; i < 3000; i++) begin
      enable = ($urandom_range(0, 9) != 0);
      intr   = ($urandom_range(0, 9) < 7);
      ready  = ($urandom_range(0, 9) < 4);
      gnt    = req_o && ($urandom_range(0, 1) == 1);
      rvalid = outstanding && ($urandom_range(0, 1) == 1);
      if (rvalid) begin
        if ($urandom_range(0, 7) == 0) w = gen_last;
        else next_word(w);
        rdata = w;
      end
      tick();
    end
    r0 = reads;
    check_eq("rand_liveness", 32'(r0 > 20), 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
